dkong3_audio_post: RTL and testbench

- Post-processing stage directly downstream of the sound sub-system's mixed signed 16-bit output.
- Boxcar-averages and decimates the per-CPU-cycle mix by 2^DECIM_LOG2, then applies a DC-blocking high-pass.
- Saturates and emits one signed 16-bit audio sample with a one-cycle valid strobe, ready for the top-level audio path.
- Runs in the sound sub-clock domain, using the CPU clock-enable as the sample strobe.

---
 rtl/dkong3_audio_post_if.sv | 21 ++
 rtl/dkong3_audio_post.sv | 140 ++++++++++++++
 tb/tb_dkong3_audio_post.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dkong3_audio_post_if.sv
// dkong3_audio_post_if
//   Sample stream between the sound mixer and the audio post-processor.
//   master : mixer side, drives I_CE / I_SAMPLE / I_MUTE, receives O_AUDIO / O_VALID
//   slave  : post-processor side
interface dkong3_audio_post_if;
  logic               I_CE;
  logic signed [15:0] I_SAMPLE;
  logic               I_MUTE;
  logic signed [15:0] O_AUDIO;
  logic               O_VALID;

  modport master (
    output I_CE, I_SAMPLE, I_MUTE,
    input  O_AUDIO, O_VALID
  );

  modport slave (
    input  I_CE, I_SAMPLE, I_MUTE,
    output O_AUDIO, O_VALID
  );
endinterface

// File: rtl/dkong3_audio_post.sv
// dkong3_audio_post
//   Boxcar-average / decimate the per-CPU-cycle mix by 2^DECIM_LOG2, pass the
//   result through a DC-blocking high-pass and emit a saturated signed 16-bit
//   sample with a one-cycle valid strobe.
// Ports:
//   I_SUBCLK  sound sub-clock, rising edge
//   I_RESETn  asynchronous active-low reset
//   bus       slave side of dkong3_audio_post_if
//             I_CE/I_SAMPLE/I_MUTE in, O_AUDIO/O_VALID out
//
// state  | meaning
// ST_ACC | waiting for the accumulator to complete a block
// ST_DC  | DC-blocker update of y_fx and x_prev
// ST_OUT | mute/saturate y_fx into O_AUDIO, pulse O_VALID
module dkong3_audio_post #(
  parameter int DECIM_LOG2 = 4,
  parameter int DCB_SHIFT  = 10
) (
  input  logic                I_SUBCLK,
  input  logic                I_RESETn,
  dkong3_audio_post_if.slave  bus
);

  localparam int AW = 16 + DECIM_LOG2;

  // Q17.8 clamp limits for y_fx
  localparam logic signed [27:0] Y_MIN = -28'sd8388608;
  localparam logic signed [27:0] Y_MAX =  28'sd8388607;

  // ---------------- accumulator / decimator ----------------
  logic signed [AW-1:0]         acc_q, acc_d;
  logic signed [AW-1:0]         acc_sum;
  logic signed [AW-1:0]         avg_full;
  logic [DECIM_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [15:0]           avg_q, avg_d;
  logic                         block_done_q, block_done_d;

  always_comb begin
    acc_sum      = acc_q + {{DECIM_LOG2{bus.I_SAMPLE[15]}}, bus.I_SAMPLE};
    // arithmetic shift floors toward -infinity; the result always fits 16 bits
    avg_full     = acc_sum >>> DECIM_LOG2;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    avg_d        = avg_q;
    block_done_d = 1'b0;
    if (bus.I_CE) begin
      if (cnt_q == '1) begin
        avg_d        = avg_full[15:0];
        acc_d        = '0;
        cnt_d        = '0;
        block_done_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_SUBCLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      avg_q        <= '0;
      block_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      avg_q        <= avg_d;
      block_done_q <= block_done_d;
    end
  end

  // ---------------- DC blocker datapath ----------------
  typedef enum logic [1:0] {ST_ACC, ST_DC, ST_OUT} state_t;

  state_t              state_q;
  logic signed [15:0]  x_prev_q;
  logic signed [25:0]  y_fx_q;
  logic signed [15:0]  audio_q;
  logic                valid_q;

  logic signed [16:0]  diff;
  logic signed [27:0]  t_full;
  logic signed [25:0]  y_next;
  logic signed [25:0]  y_int;
  logic signed [15:0]  audio_sat;

  always_comb begin
    diff   = 17'(avg_q) - 17'(x_prev_q);
    // 28 bits holds the worst case of all three terms without wrapping
    t_full = (28'(diff) <<< 8) + 28'(y_fx_q) - 28'(y_fx_q >>> DCB_SHIFT);
    if (t_full < Y_MIN)
      y_next = Y_MIN[25:0];
    else if (t_full > Y_MAX)
      y_next = Y_MAX[25:0];
    else
      y_next = t_full[25:0];

    y_int = y_fx_q >>> 8;
    if (y_int > 26'sd32767)
      audio_sat = 16'sh7fff;
    else if (y_int < -26'sd32768)
      audio_sat = 16'sh8000;
    else
      audio_sat = y_int[15:0];
  end

  // block_done seen outside ST_ACC is dropped on purpose
  always_ff @(posedge I_SUBCLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q  <= ST_ACC;
      x_prev_q <= '0;
      y_fx_q   <= '0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_ACC: begin
          if (block_done_q) state_q <= ST_DC;
        end
        ST_DC: begin
          y_fx_q   <= y_next;
          x_prev_q <= avg_q;
          state_q  <= ST_OUT;
        end
        ST_OUT: begin
          audio_q <= bus.I_MUTE ? 16'sd0 : audio_sat;
          valid_q <= 1'b1;
          state_q <= ST_ACC;
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign bus.O_AUDIO = audio_q;
  assign bus.O_VALID = valid_q;

endmodule

// File: tb/tb_dkong3_audio_post.sv
module tb_dkong3_audio_post;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   edge_cnt;
  int   ce_edge;
  int   valid_edge;
  int   vcount;
  int   vaudio;
  int   vwide;
  logic valid_prev;

  dkong3_audio_post_if bus ();

  dkong3_audio_post #(.DECIM_LOG2(4), .DCB_SHIFT(10)) dut (
    .I_SUBCLK (clk),
    .I_RESETn (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (bus.O_VALID) begin
      vcount++;
      vaudio     = int'($signed(bus.O_AUDIO));
      valid_edge = edge_cnt;
      if (valid_prev) vwide++;
    end
    valid_prev = bus.O_VALID;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: constant v; 1: +v/-v alternating; 2: zeros with v at index 15
  task automatic run_ces(input int mode, input int v, input int first, input int n);
    int s;
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      case (mode)
        0:       s = v;
        1:       s = (i % 2 == 0) ? v : -v;
        default: s = (i == 15) ? v : 0;
      endcase
      bus.I_SAMPLE = 16'(s);
      bus.I_CE     = 1'b1;
      @(negedge clk);
      ce_edge  = edge_cnt;
      bus.I_CE = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic block(input string tag, input int mode, input int v, input int exp);
    int vc0;
    vc0 = vcount;
    run_ces(mode, v, 0, 16);
    chk({tag, "_npulse"}, vcount - vc0, 1);
    chk(tag, vaudio, exp);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int vc0;
    n_cmp = 0; n_err = 0; edge_cnt = 0; vcount = 0; vaudio = 0; vwide = 0;
    ce_edge = 0; valid_edge = 0; valid_prev = 1'b0;
    rst_n = 1'b0;
    bus.I_CE = 1'b0; bus.I_SAMPLE = '0; bus.I_MUTE = 1'b0;

    // CE pulses while held in reset must produce nothing
    run_ces(0, 1000, 0, 20);
    chk("rst_valid", vcount, 0);
    chk("rst_audio", int'($signed(bus.O_AUDIO)), 0);
    chk("rst_vflag", int'(bus.O_VALID), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first block: 15 CEs give no output, the 16th does after 3 edges
    run_ces(0, 1000, 0, 15);
    chk("first_early", vcount, 0);
    run_ces(0, 1000, 15, 1);
    chk("first_npulse", vcount, 1);
    chk("first_lat", valid_edge - ce_edge, 3);
    chk("dc_1", vaudio, 1000);

    // DC decay: y_fx 255750, 255501, 255252
    block("dc_2", 0, 1000, 999);
    block("dc_3", 0, 1000, 998);
    block("dc_4", 0, 1000, 997);
    repeat (30) @(negedge clk);
    chk("hold", int'($signed(bus.O_AUDIO)), 997);

    // averaging from zero state
    do_reset();
    chk("rst2_audio", int'($signed(bus.O_AUDIO)), 0);
    block("avg_alt", 1, 100, 0);
    do_reset();
    block("avg_one160", 2, 160, 10);
    do_reset();
    block("avg_neg1", 0, -1, -1);

    // saturation: 32767 twice, then a full-scale negative step
    do_reset();
    block("sat_a", 0, 32767, 32767);
    block("sat_b", 0, 32767, 32735);
    block("sat_step", 0, -32768, -32768);
    block("sat_after", 0, -32768, -32736);

    // mute: filter keeps updating while output is forced to 0
    do_reset();
    bus.I_MUTE = 1'b1;
    block("mute_out", 0, 5000, 0);
    chk("mute_lat", valid_edge - ce_edge, 3);
    bus.I_MUTE = 1'b0;
    block("unmute", 0, 5000, 4995);

    // reset mid-block discards the partial accumulation
    do_reset();
    run_ces(0, 1000, 0, 7);
    do_reset();
    vc0 = vcount;
    run_ces(0, 1000, 0, 15);
    chk("midrst_early", vcount - vc0, 0);
    run_ces(0, 1000, 15, 1);
    chk("midrst_npulse", vcount - vc0, 1);
    chk("midrst_lat", valid_edge - ce_edge, 3);
    chk("midrst_out", vaudio, 1000);

    chk("valid_width", vwide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
